mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits between the two caches (instruction cache = client 0, data cache = client 1) and the single main-memory port.
- Multiplexes both caches' memory request/data channels onto one memory interface using round-robin arbitration.
- Tracks outstanding read bursts so that each 4-beat response is steered back to the cache that issued the read.
- Adds no latency on the request path when the block is uncontended.

Parameters:
- MEM_ADDR_BITS, 28, line address width (`CPU_ADDR_BITS-2-`ceilLog2(`MEM_DATA_BITS/`CPU_INST_BITS)).
- MEM_DATA_BITS, `MEM_DATA_BITS (128), memory beat width.
- BEATS, 4, response beats per read request.
- MAX_OUTSTANDING, 4, depth of the read-owner FIFO (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- c{0,1}_req_valid  in  1  client request valid.
- c{0,1}_req_ready  out  1  client request accepted this cycle.
- c{0,1}_req_addr  in  MEM_ADDR_BITS  line address.
- c{0,1}_req_rw  in  1  1 = write, 0 = read.
- c{0,1}_req_data_valid  in  1  client write data valid.
- c{0,1}_req_data_ready  out  1  client write data accepted.
- c{0,1}_req_data_bits  in  MEM_DATA_BITS  write data.
- c{0,1}_req_data_mask  in  MEM_DATA_BITS/8  byte mask.
- c{0,1}_resp_valid  out  1  response beat for this client.
- c{0,1}_resp_data  out  MEM_DATA_BITS  response data, broadcast to both clients.
- mem_req_valid, mem_req_ready, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_req_data_bits, mem_req_data_mask, mem_resp_valid, mem_resp_data: memory-side counterparts. Directions are mirrored; widths are as above.

Behaviour:
- Reset state: lock=0, last_grant=0, FIFO empty, beat_cnt=0, req_done=0, data_done=0.
- Reset outputs: all valid and ready outputs are 0 while reset is high.
- A reset asserted mid-burst discards the outstanding-read state.
- Grant when unlocked:
  - If exactly one client is valid, that client is granted.
  - If both are valid, the client != last_grant is granted, so c1 wins the first tie after reset.
  - The grant is combinational, giving 0-cycle added latency.
- Lock: if the granted client's request is not accepted in the same cycle, set lock=1 and hold locked_id until the transaction completes. The grant must not switch while a cache holds valid.
- Request forwarding: mem_req_* is driven from the granted client.
  - mem_req_valid = granted valid AND NOT (read AND FIFO full).
  - c_req_ready(granted) = mem_req_ready AND mem_req_valid.
  - The other client's ready is 0.
- Data forwarding: mem_req_data_valid = granted data_valid AND granted rw.
  - Read-side data_valid is masked because the caches tie data_valid to req_valid.
  - c_req_data_ready(granted) = mem_req_data_ready for a write, and 0 otherwise.
- Transaction completion:
  - A read completes on the request handshake. At that point, push the owner ID into the FIFO.
  - A write completes once both the request and data handshakes have occurred, in either order or in the same cycle. The sticky flags req_done and data_done track this.
  - Once the request handshake has occurred, mem_req_valid is held 0 until the data handshake completes, and vice versa.
  - On completion: lock=0, last_grant = owner, flags cleared.
- Read-owner FIFO:
  - When the FIFO is full, no read may issue. Writes still issue.
  - A push and a pop in the same cycle are both performed.
- Response steering:
  - mem_resp_valid raises c{head}_resp_valid in the same cycle (combinational); the other client's resp_valid is 0.
  - beat_cnt increments per response beat. On beat BEATS-1, the FIFO head pops and beat_cnt wraps to 0.
  - A response arriving with the FIFO empty is dropped: both resp_valid outputs stay 0. The bench flags this as a protocol error.
- Concurrency: a response to one client may coincide with a new request from either client. These paths are independent.

Test Plan:
- Only c0 issues a read of addr 0x0000010 with mem_req_ready=1 → same cycle mem_req_valid=1, mem_req_addr=0x0000010, c0_req_ready=1. Four beats 0xA..0xD → c0_resp_valid high for 4 cycles, c1_resp_valid stays 0.
- Both clients request a read in the first cycle after reset → c1 granted first, then c0. Response bursts are steered c1 then c0 in order.
- c1 issues a write to 0x0000020 while mem_req_ready=0 for 3 cycles and c0 raises valid during the stall → grant stays on c1. On ready, data 0x1234..., mask 0xFFFF forwarded; c0 is then granted.
- Write with mem_req_ready=1 but mem_req_data_ready delayed 2 cycles → c1_req_ready pulses once, mem_req_valid is then held 0, lock is held until data_ready, then released.
- Five back-to-back reads with no responses → the 5th read is blocked (mem_req_valid=0). A write from the other client still issues. After the first burst's 4th beat, the 5th read issues.
- Assert reset after 2 beats of a burst → both resp_valid=0, FIFO empty. A subsequent stray mem_resp_valid is dropped.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the instruction cache (client 0) and the data
// cache (client 1) in front of the single main-memory port. It steers each
// 4-beat read response back to the cache that issued the read.
//
// Handshake rule for every channel: a transfer happens in a cycle where
// valid and ready are both high. A producer holds valid and its payload
// stable until that transfer. Ready may depend on valid.
module mem_arbiter #(
    parameter int MEM_ADDR_BITS   = 28,
    parameter int MEM_DATA_BITS   = 128,
    parameter int BEATS           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    // client 0 (instruction cache)
    input  logic                       c0_req_valid,
    output logic                       c0_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   c0_req_addr,
    input  logic                       c0_req_rw,
    input  logic                       c0_req_data_valid,
    output logic                       c0_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                       c0_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   c0_resp_data,
    // client 1 (data cache)
    input  logic                       c1_req_valid,
    output logic                       c1_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   c1_req_addr,
    input  logic                       c1_req_rw,
    input  logic                       c1_req_data_valid,
    output logic                       c1_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                       c1_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   c1_resp_data,
    // memory side
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic               lock_id_q, lock_id_d;
    logic               last_q, last_d;
    logic               req_done_q, req_done_d;
    logic               data_done_q, data_done_d;

    logic               fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [BEAT_W-1:0]  beat_q;

    logic fifo_full, fifo_empty, elig0, elig1, active, gid;
    logic g_valid, g_rw, g_dvalid, req_hs, data_hs, dready, done;
    logic resp_hit, head, push, pop;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // A read is not a candidate while no owner slot is free, so a waiting
    // write from the other cache can still get through.
    assign elig0 = c0_req_valid && (c0_req_rw || !fifo_full);
    assign elig1 = c1_req_valid && (c1_req_rw || !fifo_full);

    // Combinational grant: locked owner first, otherwise round-robin on ties.
    always_comb begin
        active = 1'b0;
        gid    = 1'b0;
        if (state_q == ST_LOCKED) begin
            active = 1'b1;
            gid    = lock_id_q;
        end else begin
            active = elig0 || elig1;
            gid    = (elig0 && elig1) ? ~last_q : elig1;
        end
    end

    assign g_valid  = gid ? c1_req_valid      : c0_req_valid;
    assign g_rw     = gid ? c1_req_rw         : c0_req_rw;
    assign g_dvalid = gid ? c1_req_data_valid : c0_req_data_valid;

    assign mem_req_addr      = gid ? c1_req_addr      : c0_req_addr;
    assign mem_req_rw        = g_rw;
    assign mem_req_data_bits = gid ? c1_req_data_bits : c0_req_data_bits;
    assign mem_req_data_mask = gid ? c1_req_data_mask : c0_req_data_mask;

    // Each half of a write is presented only until it has been accepted once.
    assign mem_req_valid      = !reset && active && g_valid && !req_done_q
                                && (g_rw || !fifo_full);
    assign mem_req_data_valid = !reset && active && g_dvalid && g_rw && !data_done_q;

    assign req_hs  = mem_req_valid && mem_req_ready;
    assign data_hs = mem_req_data_valid && mem_req_data_ready;
    assign dready  = !reset && active && g_rw && mem_req_data_ready && !data_done_q;

    assign c0_req_ready      = !gid && req_hs;
    assign c1_req_ready      =  gid && req_hs;
    assign c0_req_data_ready = !gid && dready;
    assign c1_req_data_ready =  gid && dready;

    assign done = g_rw ? ((req_done_q || req_hs) && (data_done_q || data_hs)) : req_hs;

    // Lock FSM next state: hold the grant until the transaction completes.
    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        last_d      = last_q;
        req_done_d  = req_done_q;
        data_done_d = data_done_q;
        if (active) begin
            if (done) begin
                state_d     = ST_IDLE;
                last_d      = gid;
                req_done_d  = 1'b0;
                data_done_d = 1'b0;
            end else begin
                state_d     = ST_LOCKED;
                lock_id_d   = gid;
                req_done_d  = req_done_q || req_hs;
                data_done_d = data_done_q || data_hs;
            end
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lock_id_q   <= 1'b0;
            last_q      <= 1'b0;
            req_done_q  <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            last_q      <= last_d;
            req_done_q  <= req_done_d;
            data_done_q <= data_done_d;
        end
    end

    // Response steering: a beat with no recorded owner is dropped.
    assign resp_hit      = !reset && mem_resp_valid && !fifo_empty;
    assign head          = fifo_q[rd_ptr_q];
    assign c0_resp_valid = resp_hit && !head;
    assign c1_resp_valid = resp_hit &&  head;
    assign c0_resp_data  = mem_resp_data;
    assign c1_resp_data  = mem_resp_data;

    assign push = req_hs && !g_rw;
    assign pop  = resp_hit && (beat_q == BEAT_W'(BEATS - 1));

    // Owner storage: written on each accepted read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= gid;
        end
    end

    // Owner FIFO pointers, occupancy and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (resp_hit) beat_q <= pop ? '0 : beat_q + 1'b1;
        end
    end

endmodule
